// File: rtl/alu_mdu.sv
// EX-stage integer execute unit: same-cycle ALU plus an iterative multiply/divide
// unit (one shift-add or restoring shift-subtract step per cycle) that owns HI/LO.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       alu_op,
    input  logic             start,
    output logic [WIDTH-1:0] d_out,
    output logic             zero_flag,
    output logic             exp_overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;
    localparam logic [3:0] OP_MTHI = 4'b1110;
    localparam logic [3:0] OP_MTLO = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (-v) : v;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   acc_r;      // partial product high half / running remainder
    logic [WIDTH-1:0]   wrk_r;      // multiplier being consumed / dividend becoming quotient
    logic [WIDTH-1:0]   opb_r;      // multiplicand or divisor magnitude
    logic               is_div_r;
    logic               neg_a_r;
    logic               neg_res_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               ovf_s;
    logic               mdu_start_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH-1:0]   step_acc_s;
    logic [WIDTH-1:0]   step_wrk_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    assign sum_s  = {data1[WIDTH-1], data1} + {data2[WIDTH-1], data2};
    assign diff_s = {data1[WIDTH-1], data1} - {data2[WIDTH-1], data2};

    // Same-cycle ALU result and signed-overflow flag
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        ovf_s     = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                ovf_s     = sum_s[WIDTH] ^ sum_s[WIDTH-1];
            end
            OP_SUB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                ovf_s     = diff_s[WIDTH] ^ diff_s[WIDTH-1];
            end
            OP_OR:   alu_res_s = data1 | data2;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            OP_AND:  alu_res_s = data1 & data2;
            OP_XOR:  alu_res_s = data1 ^ data2;
            OP_NOR:  alu_res_s = ~(data1 | data2);
            OP_MFHI: alu_res_s = hi_r;
            OP_MFLO: alu_res_s = lo_r;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign d_out        = alu_res_s;
    assign exp_overflow = ovf_s;
    assign zero_flag    = (data1 == data2);

    // MDU opcodes are 10xx: bit 1 selects divide, bit 0 selects unsigned
    assign mdu_start_s = start && (alu_op[3:2] == 2'b10);
    assign sign_a_s    = ~alu_op[0] & data1[WIDTH-1];
    assign sign_b_s    = ~alu_op[0] & data2[WIDTH-1];

    assign mul_sum_s   = {1'b0, acc_r} + (wrk_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    assign div_trial_s = {acc_r, wrk_r[WIDTH-1]} - {1'b0, opb_r};

    // One iteration step of the shift-add multiplier or restoring divider
    always_comb begin
        step_acc_s = acc_r;
        step_wrk_s = wrk_r;
        if (is_div_r) begin
            if (!div_trial_s[WIDTH]) begin
                step_acc_s = div_trial_s[WIDTH-1:0];
                step_wrk_s = {wrk_r[WIDTH-2:0], 1'b1};
            end else begin
                step_acc_s = {acc_r[WIDTH-2:0], wrk_r[WIDTH-1]};
                step_wrk_s = {wrk_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc_s = mul_sum_s[WIDTH:1];
            step_wrk_s = {mul_sum_s[0], wrk_r[WIDTH-1:1]};
        end
    end

    assign prod_s     = {step_acc_s, step_wrk_s};
    assign prod_fix_s = neg_res_r ? (-prod_s) : prod_s;

    // Sign fix-up of the final step; a zero divisor yields an all-ones quotient
    always_comb begin
        res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_fix_s[WIDTH-1:0];
        if (is_div_r) begin
            res_hi_s = cond_neg(step_acc_s, neg_a_r);
            res_lo_s = dz_r ? {WIDTH{1'b1}} : cond_neg(step_wrk_s, neg_res_r);
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // MDU control FSM with HI/LO and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            wrk_r     <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_a_r   <= 1'b0;
            neg_res_r <= 1'b0;
            dz_r      <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mdu_start_s) begin
                        acc_r     <= {WIDTH{1'b0}};
                        wrk_r     <= cond_neg(data1, sign_a_s);
                        opb_r     <= cond_neg(data2, sign_b_s);
                        is_div_r  <= alu_op[1];
                        neg_a_r   <= sign_a_s;
                        neg_res_r <= sign_a_s ^ sign_b_s;
                        dz_r      <= (data2 == {WIDTH{1'b0}});
                        cnt_r     <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end else if (start && (alu_op == OP_MTHI)) begin
                        hi_r <= data1;
                    end else if (start && (alu_op == OP_MTLO)) begin
                        lo_r <= data1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= step_acc_s;
                    wrk_r <= step_wrk_s;
                    if (cnt_r == LAST_STEP) begin
                        hi_r    <= res_hi_s;
                        lo_r    <= res_lo_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed and randomized ALU/MDU traffic checked
// against arithmetic reference models built on 64-bit integers.
module tb_alu_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [3:0]   alu_op;
    logic         start;
    logic [W-1:0] d_out;
    logic         zero_flag;
    logic         exp_overflow;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_hi = 32'd0;
    logic [W-1:0] exp_lo = 32'd0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .data1(data1), .data2(data2), .alu_op(alu_op),
        .start(start), .d_out(d_out), .zero_flag(zero_flag), .exp_overflow(exp_overflow),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            4'b1000: p = sa * sb;
            4'b1001: p = {32'd0, a} * {32'd0, b};
            4'b1010: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            4'b1011: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] d, output logic ov);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 64'sd0;
        d  = 32'd0;
        ov = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                s  = (op == 4'd0) ? sa + sb : sa - sb;
                d  = s[31:0];
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  d = a | b;
            4'd3:  d = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  d = (a < b) ? 32'd1 : 32'd0;
            4'd5:  d = a & b;
            4'd6:  d = a ^ b;
            4'd7:  d = ~(a | b);
            4'd12: d = exp_hi;
            4'd13: d = exp_lo;
            default: d = 32'd0;
        endcase
    endfunction

    // Launch one MDU op and follow it to completion; optional disturbance mid-run
    task automatic mdu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit disturb,
                          output int nb, output bit timeout, output int hold_bad,
                          output logic done_end, output logic done_after,
                          output logic [31:0] h, output logic [31:0] l, output logic [31:0] mflo_seen);
        nb = 0; timeout = 1'b1; hold_bad = 0; mflo_seen = 32'd0;
        @(negedge clk);
        data1 = a; data2 = b; alu_op = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            nb++;
            if (hi !== exp_hi || lo !== exp_lo) hold_bad++;
            if (disturb) begin
                if (nb == 5) begin
                    data1 = $urandom; data2 = $urandom; alu_op = 4'b1001; start = 1'b1;
                end else if (nb == 6) begin
                    alu_op = 4'b1110; data1 = 32'h0000_1234;
                end else if (nb == 7) begin
                    start = 1'b0; alu_op = 4'b1101;
                    #1 mflo_seen = d_out;
                end
            end
            @(negedge clk);
        end
        done_end = done; h = hi; l = lo;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; data1 = 32'd0; data2 = 32'd0; alu_op = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_assert busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_release busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
    endtask

    task automatic test_alu_directed;
        logic [3:0]  ops [7] = '{4'b0000, 4'b0001, 4'b0100, 4'b0011, 4'b0000, 4'b0001, 4'b1000};
        logic [31:0] as  [7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h5, 32'h3};
        logic [31:0] bs  [7] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h4};
        logic [31:0] ed  [7] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        eo  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            alu_op = ops[i]; data1 = as[i]; data2 = bs[i]; start = 1'b0;
            #1;
            checks++;
            if (d_out !== ed[i] || exp_overflow !== eo[i] || zero_flag !== (as[i] == bs[i])) begin
                failures++;
                $display("FAIL alu_dir[%0d] op=%b d_out=%h ovf=%b zf=%b expected d_out=%h ovf=%b zf=%b",
                         i, ops[i], d_out, exp_overflow, zero_flag, ed[i], eo[i], (as[i] == bs[i]));
            end
        end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        alu_op = 4'b1110; data1 = 32'h0000_1234; start = 1'b1;
        @(negedge clk);
        alu_op = 4'b1111; data1 = 32'h0000_5678;
        checks++;
        if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mthi hi=%h busy=%b done=%b expected hi=00001234 busy=0 done=0", hi, busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b expected 00001234 00005678 0 0", hi, lo, busy, done);
        end
        exp_hi = 32'h1234;
        exp_lo = 32'h5678;
    endtask

    task automatic test_alu_random;
        logic [31:0] specials [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] a, b, ed;
        logic [3:0]  op;
        logic        eo;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 4) == 0) ? a : (($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom);
            @(negedge clk);
            alu_op = op; data1 = a; data2 = b; start = 1'b0;
            #1;
            alu_model(op, a, b, ed, eo);
            checks++;
            if (d_out !== ed || exp_overflow !== eo || zero_flag !== (a == b)) begin
                failures++;
                $display("FAIL alu_rand op=%b a=%h b=%h d_out=%h ovf=%b zf=%b expected %h %b %b",
                         op, a, b, d_out, exp_overflow, zero_flag, ed, eo, (a == b));
            end
        end
    endtask

    task automatic test_mdu_directed;
        logic [3:0]  ops [6] = '{4'b1000, 4'b1001, 4'b1010, 4'b1010, 4'b1011, 4'b1010};
        logic [31:0] as  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7, 32'hFFFF_FFF9};
        logic [31:0] bs  [6] = '{32'h7, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h7, 32'hFFFF_FFF9};
        logic [31:0] el  [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int nb, hold_bad; bit to; logic de, da; logic [31:0] h, l, m;
        for (int i = 0; i < 6; i++) begin
            mdu_op(ops[i], as[i], bs[i], 1'b0, nb, to, hold_bad, de, da, h, l, m);
            checks++;
            if (to || nb != W || hold_bad != 0 || de !== 1'b1 || da !== 1'b0 || h !== eh[i] || l !== el[i]) begin
                failures++;
                $display("FAIL mdu_dir[%0d] timeout=%b busy_cycles=%0d hold_bad=%0d done=%b/%b hi=%h lo=%h expected busy_cycles=%0d done=1/0 hi=%h lo=%h",
                         i, to, nb, hold_bad, de, da, h, l, W, eh[i], el[i]);
            end
            exp_hi = eh[i];
            exp_lo = el[i];
        end
    endtask

    task automatic test_mdu_random;
        int nb, hold_bad; bit to; logic de, da; logic [31:0] h, l, m, a, b;
        logic [3:0] op; logic [63:0] e;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(8, 11));
            a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(0, 20)) - 32'd10;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            e = mdu_model(op, a, b);
            mdu_op(op, a, b, 1'b0, nb, to, hold_bad, de, da, h, l, m);
            checks++;
            if (to || nb != W || hold_bad != 0 || de !== 1'b1 || da !== 1'b0 || {h, l} !== e) begin
                failures++;
                $display("FAIL mdu_rand op=%b a=%h b=%h timeout=%b busy_cycles=%0d hold_bad=%0d done=%b/%b hi:lo=%h expected %h",
                         op, a, b, to, nb, hold_bad, de, da, {h, l}, e);
            end
            exp_hi = e[63:32];
            exp_lo = e[31:0];
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] op1, op2; logic [31:0] a1, b1, a2, b2; logic [63:0] e1, e2;
        int nb; bit to;
        op1 = 4'($urandom_range(8, 11)); a1 = $urandom; b1 = $urandom;
        op2 = 4'($urandom_range(8, 11)); a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        e1 = mdu_model(op1, a1, b1);
        e2 = mdu_model(op2, a2, b2);
        @(negedge clk);
        alu_op = op1; data1 = a1; data2 = b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin to = 1'b0; break; end
            @(negedge clk);
        end
        checks++;
        if (to || done !== 1'b1 || {hi, lo} !== e1) begin
            failures++;
            $display("FAIL b2b_first timeout=%b done=%b hi:lo=%h expected done=1 hi:lo=%h", to, done, {hi, lo}, e1);
        end
        alu_op = op2; data1 = a2; data2 = b2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept busy=%b expected 1", busy);
        end
        nb = 0; to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin to = 1'b0; break; end
            nb++;
            @(negedge clk);
        end
        checks++;
        if (to || nb != W || done !== 1'b1 || {hi, lo} !== e2) begin
            failures++;
            $display("FAIL b2b_second timeout=%b busy_cycles=%0d done=%b hi:lo=%h expected %0d 1 %h", to, nb, done, {hi, lo}, W, e2);
        end
        exp_hi = e2[63:32];
        exp_lo = e2[31:0];
        @(negedge clk);
    endtask

    task automatic test_run_ignores;
        int nb, hold_bad, extra_done, extra_busy; bit to; logic de, da; logic [31:0] h, l, m, old_lo;
        old_lo = exp_lo;
        mdu_op(4'b1001, 32'd5, 32'd5, 1'b1, nb, to, hold_bad, de, da, h, l, m);
        checks++;
        if (m !== old_lo) begin
            failures++;
            $display("FAIL mflo_during_run d_out=%h expected old lo %h", m, old_lo);
        end
        checks++;
        if (to || nb != W || hold_bad != 0 || de !== 1'b1 || da !== 1'b0 || h !== 32'd0 || l !== 32'd25) begin
            failures++;
            $display("FAIL run_ignores timeout=%b busy_cycles=%0d hold_bad=%0d done=%b/%b hi=%h lo=%h expected %0d 0 1/0 00000000 00000019",
                     to, nb, hold_bad, de, da, h, l, W);
        end
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++;
        if (extra_done != 0 || extra_busy != 0) begin
            failures++;
            $display("FAIL run_single_done extra_done=%0d extra_busy=%0d expected 0 0", extra_done, extra_busy);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd25;
    endtask

    task automatic test_reset_mid_run;
        int seen_done, seen_busy;
        @(negedge clk);
        alu_op = 4'b1010; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_run_busy busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_mid_run busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0; seen_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_done done_seen=%0d busy_seen=%0d hi=%h lo=%h expected 0 0 0 0", seen_done, seen_busy, hi, lo);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
    endtask

    initial begin
        test_reset;
        test_alu_directed;
        test_mthi_mtlo;
        test_alu_random;
        test_mdu_directed;
        test_mdu_random;
        test_back_to_back;
        test_run_ignores;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised integer execute unit for the MIPS core: a combinational ALU (add/sub with overflow trap, logic, set-less-than) merged with an iterative multiply/divide unit that owns the HI/LO registers. It sits in the EX stage. ALU results are same-cycle. MULT/DIV run for WIDTH cycles behind a start/busy/done handshake, and the pipeline stalls on busy.

## Interface
- WIDTH, 32, datapath and HI/LO width (>= 4)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data1  in  WIDTH  operand A (rs)
- data2  in  WIDTH  operand B (rt)
- alu_op  in  4  operation select
- start  in  1  launch MDU op or HI/LO write this cycle
- d_out  out  WIDTH  combinational result
- zero_flag  out  1  data1 == data2
- exp_overflow  out  1  signed overflow on add/sub
- busy  out  1  MDU iterating
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- alu_op: 0000 add, 0001 sub, 0010 or, 0011 slt (signed), 0100 sltu, 0101 and, 0110 xor, 0111 nor, 1000 mult, 1001 multu, 1010 div, 1011 divu, 1100 mfhi, 1101 mflo, 1110 mthi, 1111 mtlo.
- add/sub are computed on WIDTH+1-bit sign-extended operands. d_out = low WIDTH bits. exp_overflow = bit WIDTH XOR bit WIDTH-1. exp_overflow = 0 for all other ops.
- slt/sltu: d_out = 1 or 0, zero-extended.
- mfhi/mflo: d_out = hi/lo, the current register value. Opcodes 1000–1011, 1110, 1111 give d_out = 0.
- zero_flag is independent of alu_op.
- States: IDLE, RUN.
- In IDLE, start=1 with op mult/multu/div/divu latches data1, data2 and the op, then enters RUN. Signed ops latch operand magnitudes plus result-sign flags.
- In IDLE, start=1 with mthi/mtlo writes data1 into hi/lo at the edge, with no busy and no done. start with any other op is ignored.
- RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle, WIDTH steps. The final step writes hi/lo, fixes signs, pulses done and returns to IDLE.
- mult: {hi,lo} = 2*WIDTH-bit product.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
- Divide by zero (div or divu): lo = all ones, hi = dividend. No exception.
- div of the most negative value by -1: lo = most negative value, hi = 0.
- start during RUN is ignored, including mthi/mtlo. Operand changes during RUN are ignored.
- hi/lo hold their old values throughout RUN.

## Timing
- Reset: hi = 0, lo = 0, busy = 0, done = 0, state = IDLE. Combinational outputs follow inputs.
- A start sampled at edge E0: busy = 1 after E0 through edge E0+WIDTH. At edge E0+WIDTH, hi/lo are updated, done = 1 for the next cycle only, and busy = 0.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- mthi/mtlo: the value is visible on hi/lo the cycle after the edge.
- rst_n asserted mid-RUN: abort immediately, with hi/lo/busy/done = 0. No done follows.
- Latency: ALU ops 0 cycles. MDU ops WIDTH+1 cycles from start to first readable HI/LO.

## Test plan
- WIDTH=32, add 0x7FFFFFFF + 0x00000001 -> d_out 0x80000000, exp_overflow 1. sub 0x80000000 - 1 -> d_out 0x7FFFFFFF, exp_overflow 1. sltu 1, 0xFFFFFFFF -> 1. slt 1, 0xFFFFFFFF -> 0.
- mult -3 × 7 -> busy high 32 cycles, then done pulse and hi 0xFFFFFFFF, lo 0xFFFFFFEB. multu 0xFFFFFFFF × 2 -> hi 0x00000001, lo 0xFFFFFFFE.
- div -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0. divu 7 / 0 -> lo 0xFFFFFFFF, hi 0x00000007.
- mthi 0x1234 then mtlo 0x5678 -> hi 0x1234, lo 0x5678, no done. mthi 0x1234 issued during RUN -> ignored.
- Start multu 5 × 5, change data1/data2 and re-assert start during RUN -> single done, lo 25. mflo during RUN returns the old lo.
- Assert rst_n=0 at cycle 10 of a div -> hi/lo/busy 0, no done.
